// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional saturation (ports sat_mode/sat) is enabled by defining CLA_ADDSUB_SAT_EN.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 8,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
`ifdef CLA_ADDSUB_SAT_EN
    input  logic             sat_mode,
    output logic             sat,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NG  = WIDTH / BLOCK;
    localparam int GPS = NG / STAGES;
    localparam int MID = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L   = STAGES - 1;

    if (((WIDTH % BLOCK) != 0) || ((NG % STAGES) != 0)) begin : g_bad_params
        $error("cla_addsub_pipe: WIDTH/BLOCK/STAGES divisibility violated");
    end

    // Resolves groups k*GPS..(k+1)*GPS-1; returns {carry out of the stage, partial sum}.
    function automatic logic [WIDTH:0] stage_calc(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] psum,
                                                  input logic c_in,
                                                  input int k);
        logic [WIDTH-1:0] x, gb, s;
        logic c, gg, gp, bc;
        int idx;
        x  = a ^ b;
        gb = a & b;
        s  = psum;
        c  = c_in;
        for (int i = 0; i < GPS; i++) begin
            gg = 1'b0;
            gp = 1'b1;
            bc = c;
            for (int j = 0; j < BLOCK; j++) begin
                idx    = (k * GPS + i) * BLOCK + j;
                gg     = gb[idx] | (x[idx] & gg);
                gp     = gp & x[idx];
                s[idx] = x[idx] ^ bc;
                bc     = gb[idx] | (x[idx] & bc);
            end
            c = gg | (gp & c);
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0]  r_a   [MID];
    logic [WIDTH-1:0]  r_b   [MID];
    logic [WIDTH-1:0]  r_ps  [MID];
    logic [MID-1:0]    r_c;
    logic [MID-1:0]    r_vld;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];
    logic [WIDTH-1:0]  w_ps  [STAGES];
    logic [WIDTH:0]    w_res [STAGES];
    logic [STAGES-1:0] w_c;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_adv;

    // Operands are stored already in effective form, so subtraction is just addition.
    assign w_a[0]  = in1;
    assign w_b[0]  = in2 ^ {WIDTH{sub}};
    assign w_ps[0] = '0;
    assign w_c[0]  = sub ? ~cin : cin;
    assign w_v[0]  = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign w_a[k]  = r_a[k-1];
        assign w_b[k]  = r_b[k-1];
        assign w_ps[k] = r_ps[k-1];
        assign w_c[k]  = r_c[k-1];
        assign w_v[k]  = r_vld[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_calc
        assign w_res[k] = stage_calc(w_a[k], w_b[k], w_ps[k], w_c[k], k);
    end

    // Handshake: a transfer happens on a rising edge where valid && ready; a
    // register advances when it is empty or its successor advances, and
    // in_ready is the stage-0 advance, combinational from out_ready.
    always_comb begin
        w_adv    = '0;
        w_adv[L] = !r_out_valid || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !r_vld[k] || w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            r_c   <= '0;
            for (int k = 0; k < MID; k++) begin
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_ps[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_v[k];
                    if (w_v[k]) begin
                        r_a[k]  <= w_a[k];
                        r_b[k]  <= w_b[k];
                        r_ps[k] <= w_res[k][WIDTH-1:0];
                        r_c[k]  <= w_res[k][WIDTH];
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] w_fin_sum;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_cout;
    logic             w_fin_cmsb;
    logic             w_fin_ovf;
    logic             w_fin_sat;

    assign w_fin_sum  = w_res[L][WIDTH-1:0];
    assign w_fin_cout = w_res[L][WIDTH];
    // Carry into the MSB recovered from the MSB sum bit.
    assign w_fin_cmsb = w_a[L][WIDTH-1] ^ w_b[L][WIDTH-1] ^ w_fin_sum[WIDTH-1];
    assign w_fin_ovf  = w_fin_cmsb ^ w_fin_cout;

`ifdef CLA_ADDSUB_SAT_EN
    logic [MID-1:0]    r_sm;
    logic [STAGES-1:0] w_sm;
    logic              r_sat;

    assign w_sm[0] = sat_mode;
    for (genvar k = 1; k < STAGES; k++) begin : g_sm_link
        assign w_sm[k] = r_sm[k-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sm <= '0;
        end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
                if (w_adv[k] && w_v[k]) r_sm[k] <= w_sm[k];
            end
        end
    end

    // Overflow implies equal operand signs, so operand A's sign picks the limit.
    assign w_fin_sat = w_sm[L] & w_fin_ovf;
    assign w_fin_res = !w_fin_sat ? w_fin_sum :
                       w_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sat <= 1'b0;
        end else if (w_adv[L] && w_v[L]) begin
            r_sat <= w_fin_sat;
        end
    end

    assign sat = r_sat;
`else
    assign w_fin_sat = 1'b0;
    assign w_fin_res = w_fin_sum;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv[L]) begin
            r_out_valid <= w_v[L];
            if (w_v[L]) begin
                r_sum  <= w_fin_res;
                r_cout <= w_fin_cout;
                r_ovf  <= w_fin_ovf;
                r_zero <= (w_fin_res == '0);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule
